// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for 640x480@60 on the 25 MHz pixel clock.
// Walks a column/row counter pair over the full H_TOTAL x V_TOTAL raster and
// decodes the active-video qualifier, sync pulses and a once-per-frame tick.
//
// Ports:
//   vga_clk     in   pixel clock, the only clock
//   reset       in   synchronous, active-high reset
//   DrawX       out  current column, 0..H_TOTAL-1
//   DrawY       out  current row, 0..V_TOTAL-1
//   blank       out  1 = active video, 0 = blanking
//   hs          out  horizontal sync, active low
//   vs          out  vertical sync, active low
//   frame_tick  out  one-cycle pulse at (0, V_VISIBLE)
//   frame_count out  frames completed, mod 256
//
// Optional macro VGA_SYNC_ALIGN_EN: delays hs/vs by two extra registers so they
// line up with the two-cycle downstream RGB path. All other outputs unchanged.

module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_blank;
  logic       r_hs;
  logic       r_vs;
  logic       r_tick;
  logic [7:0] r_fcnt;

  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_blank_nxt;
  logic       w_hs_nxt;
  logic       w_vs_nxt;
  logic       w_tick_nxt;

  // Next raster position and the decode of that position, so the registered
  // qualifiers describe the same (DrawX, DrawY) they are presented with.
  always_comb begin
    w_x_nxt = r_x + 10'd1;
    w_y_nxt = r_y;
    if (r_x == H_LAST) begin
      w_x_nxt = 10'd0;
      if (r_y == V_LAST) begin
        w_y_nxt = 10'd0;
      end else begin
        w_y_nxt = r_y + 10'd1;
      end
    end
    w_blank_nxt = (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
    w_hs_nxt    = !((w_x_nxt >= HS_START) && (w_x_nxt < HS_END));
    w_vs_nxt    = !((w_y_nxt >= VS_START) && (w_y_nxt < VS_END));
    w_tick_nxt  = (w_x_nxt == 10'd0) && (w_y_nxt == V_VIS);
  end

  // Raster counters and decoded outputs.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_x     <= 10'd0;
      r_y     <= 10'd0;
      r_blank <= 1'b1;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_tick  <= 1'b0;
    end else begin
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_blank <= w_blank_nxt;
      r_hs    <= w_hs_nxt;
      r_vs    <= w_vs_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Frame counter advances on the edge that ends the tick cycle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_fcnt <= 8'd0;
    end else if (r_tick) begin
      r_fcnt <= r_fcnt + 8'd1;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic [1:0] r_hs_pipe;
  logic [1:0] r_vs_pipe;

  // Two-stage sync delay matching the ROM read + RGB register downstream.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hs_pipe <= 2'b11;
      r_vs_pipe <= 2'b11;
    end else begin
      r_hs_pipe <= {r_hs_pipe[0], r_hs};
      r_vs_pipe <= {r_vs_pipe[0], r_vs};
    end
  end

  assign hs = r_hs_pipe[1];
  assign vs = r_vs_pipe[1];
`else
  assign hs = r_hs;
  assign vs = r_vs;
`endif

  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign blank       = r_blank;
  assign frame_tick  = r_tick;
  assign frame_count = r_fcnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance (default 640x480 timing) and a
// shrunken instance (20x10 raster) so whole frames and the 8-bit frame counter
// wrap fit in a short run. Both are checked every cycle against an arithmetic
// raster model derived from elapsed clocks since reset.

module tb_vga_timing_gen;

`ifdef VGA_SYNC_ALIGN_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  // Small raster: H 12+2+3+3 = 20, V 6+1+2+1 = 10, frame = 200 clocks.
  localparam int S_HV = 12, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VV = 6,  S_VF = 1, S_VS = 2, S_VB = 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       tick;
    logic [7:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic [9:0] f_x, f_y, s_x, s_y;
  logic       f_blank, f_hs, f_vs, f_tick;
  logic       s_blank, s_hs, s_vs, s_tick;
  logic [7:0] f_fc, s_fc;

  int t = 0;
  bit seen = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_tick = -1;

  always #20 clk = ~clk;

  // Clocks elapsed since the last edge that sampled reset high.
  always @(posedge clk) begin
    if (reset) begin
      t    <= 0;
      seen <= 1'b1;
    end else begin
      t <= t + 1;
    end
  end

  vga_timing_gen u_full (
    .vga_clk(clk), .reset(reset), .DrawX(f_x), .DrawY(f_y), .blank(f_blank),
    .hs(f_hs), .vs(f_vs), .frame_tick(f_tick), .frame_count(f_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) u_small (
    .vga_clk(clk), .reset(reset), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .frame_tick(s_tick), .frame_count(s_fc)
  );

  // Expected outputs at clock count tt for a given raster geometry.
  function automatic exp_t model(int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb, int tt);
    exp_t e;
    int ht, vt, fr, pos, xx, yy, t0, ts, sx, sy;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    fr  = ht * vt;
    pos = tt % fr;
    xx  = pos % ht;
    yy  = pos / ht;
    e.x     = 10'(xx);
    e.y     = 10'(yy);
    e.blank = (xx < hv) && (yy < vv);
    e.tick  = (xx == 0) && (yy == vv);
    t0 = vv * ht;
    e.fc = (tt > t0) ? 8'(((tt - t0 - 1) / fr + 1) % 256) : 8'd0;
    ts = tt - SD;
    if (ts < 0) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
    end else begin
      sx = (ts % fr) % ht;
      sy = (ts % fr) / ht;
      e.hs = !((sx >= hv + hf) && (sx < hv + hf + hsw));
      e.vs = !((sy >= vv + vf) && (sy < vv + vf + vsw));
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s t=%0d: got %0d, expected %0d", nm, t, act, exp_v);
    end
  endtask

  // Advance one clock and check both instances against the model.
  task automatic step();
    exp_t ef, es;
    @(negedge clk);
    if (seen) begin
      ef = model(640, 16, 96, 48, 480, 10, 2, 33, t);
      es = model(S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, t);
      cmp("full.DrawX", int'(f_x), int'(ef.x));
      cmp("full.DrawY", int'(f_y), int'(ef.y));
      cmp("full.blank", int'(f_blank), int'(ef.blank));
      cmp("full.hs", int'(f_hs), int'(ef.hs));
      cmp("full.vs", int'(f_vs), int'(ef.vs));
      cmp("full.tick", int'(f_tick), int'(ef.tick));
      cmp("full.fcount", int'(f_fc), int'(ef.fc));
      cmp("small.DrawX", int'(s_x), int'(es.x));
      cmp("small.DrawY", int'(s_y), int'(es.y));
      cmp("small.blank", int'(s_blank), int'(es.blank));
      cmp("small.hs", int'(s_hs), int'(es.hs));
      cmp("small.vs", int'(s_vs), int'(es.vs));
      cmp("small.tick", int'(s_tick), int'(es.tick));
      cmp("small.fcount", int'(s_fc), int'(es.fc));
      if (t == 0) last_tick = -1;
      if (s_tick) begin
        if (last_tick >= 0) cmp("small.tick_spacing", t - last_tick, 200);
        last_tick = t;
      end
    end
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 120000 && t < target; i++) step();
    cmp("run_to", t, target);
  endtask

  initial begin
    int cnt_hs, cnt_blank, cnt_vs, cnt_tick;

    // Reset held 5 cycles: reset values every cycle.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      cmp("rst.DrawX", int'(f_x), 0);
      cmp("rst.blank", int'(f_blank), 1);
      cmp("rst.hs", int'(f_hs), 1);
      cmp("rst.vs", int'(s_vs), 1);
      cmp("rst.fcount", int'(s_fc), 0);
    end
    reset = 1'b0;

    step();
    cmp("lit.x_after_release", int'(f_x), 1);
    step();
    cmp("lit.x2", int'(f_x), 2);
    cmp("lit.y2", int'(f_y), 0);

    run_to(639);
    cmp("lit.blank_639", int'(f_blank), 1);
    step();
    cmp("lit.blank_640", int'(f_blank), 0);
    run_to(655 + SD);
    cmp("lit.hs_before", int'(f_hs), 1);
    step();
    cmp("lit.hs_fall", int'(f_hs), 0);
    run_to(751 + SD);
    cmp("lit.hs_last_low", int'(f_hs), 0);
    step();
    cmp("lit.hs_rise", int'(f_hs), 1);
    run_to(799);
    cmp("lit.x799", int'(f_x), 799);
    cmp("lit.y_line0", int'(f_y), 0);

    // One full line of the full raster: sync width and active width.
    cnt_hs = 0;
    cnt_blank = 0;
    for (int i = 0; i < 800; i++) begin
      step();
      if (i == 0) begin
        cmp("lit.x_wrap", int'(f_x), 0);
        cmp("lit.y_inc", int'(f_y), 1);
      end
      if (!f_hs) cnt_hs++;
      if (f_blank) cnt_blank++;
    end
    cmp("line.hs_low_cycles", cnt_hs, 96);
    cmp("line.active_cycles", cnt_blank, 640);

    // One full small frame: vsync width, single tick, frame wrap.
    run_to(1599);
    cmp("lit.small_x_last", int'(s_x), 19);
    cmp("lit.small_y_last", int'(s_y), 9);
    cnt_vs = 0;
    cnt_tick = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (i == 0) begin
        cmp("lit.small_wrap_x", int'(s_x), 0);
        cmp("lit.small_wrap_y", int'(s_y), 0);
      end
      if (i == 120) cmp("lit.small_tick_at_0_6", int'(s_tick), 1);
      if (!s_vs) cnt_vs++;
      if (s_tick) cnt_tick++;
    end
    cmp("frame.vs_low_cycles", cnt_vs, 40);
    cmp("frame.tick_count", cnt_tick, 1);

    // Frame counter through 255 -> 0 -> 1.
    run_to(50921);
    cmp("lit.fc_255", int'(s_fc), 255);
    run_to(51120);
    cmp("lit.fc_hold_255", int'(s_fc), 255);
    run_to(51121);
    cmp("lit.fc_wrap_0", int'(s_fc), 0);
    run_to(51321);
    cmp("lit.fc_1", int'(s_fc), 1);
    cmp("lit.full_fc_0", int'(f_fc), 0);

    // Single-cycle reset mid-frame.
    run_to(51467);
    cmp("lit.mid_x", int'(s_x), 7);
    cmp("lit.mid_y", int'(s_y), 3);
    reset = 1'b1;
    step();
    cmp("midrst.x", int'(s_x), 0);
    cmp("midrst.y", int'(s_y), 0);
    cmp("midrst.fc", int'(s_fc), 0);
    cmp("midrst.full_x", int'(f_x), 0);
    reset = 1'b0;
    step();
    cmp("midrst.resume", int'(s_x), 1);

    // Reset during a vsync line: vs released immediately.
    run_to(145);
    cmp("lit.vs_low_before_rst", int'(s_vs), 0);
    reset = 1'b1;
    step();
    cmp("vsrst.vs", int'(s_vs), 1);
    cmp("vsrst.hs", int'(s_hs), 1);
    cmp("vsrst.y", int'(s_y), 0);
    reset = 1'b0;
    run_to(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
